fifo_pop_adapter: RTL

// - Sits directly downstream of the team's fifo read port. Drives the fifo's data_o_ready and captures its

---
 rtl/buff_pkg.sv | 16 +
 rtl/skid_mem.sv | 29 ++
 rtl/fifo_pop_adapter.sv | 99 +++++++++
 3 files changed

// File: rtl/buff_pkg.sv
// Shared constants and sizing helpers for the fifo pop adapter.
// Index and count widths are derived from the skid depth.
package buff_pkg;

  localparam int DATA_WIDTH_DEF = 32;
  localparam int SKID_DEPTH_DEF = 4;

  function automatic int idx_w(input int depth);
    return (depth > 1) ? $clog2(depth) : 1;
  endfunction

  function automatic int cnt_w(input int depth);
    return idx_w(depth) + 1;
  endfunction

endpackage

// File: rtl/skid_mem.sv
// Skid buffer storage: one write port, one async read port.
// Written only when a returned fifo word is accepted.
module skid_mem
  import buff_pkg::*;
#(
  parameter int DEPTH = SKID_DEPTH_DEF,
  parameter int WIDTH = DATA_WIDTH_DEF,
  parameter int IDX_W = idx_w(DEPTH)
) (
  input  logic             clk,
  input  logic             we,
  input  logic [IDX_W-1:0] waddr,
  input  logic [WIDTH-1:0] wdata,
  input  logic [IDX_W-1:0] raddr,
  output logic [WIDTH-1:0] rdata
);

  logic [WIDTH-1:0] mem [DEPTH];

  // write the accepted word into its slot
  always_ff @(posedge clk) begin
    if (we) begin
      mem[waddr] <= wdata;
    end
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/fifo_pop_adapter.sv
// Pops a registered-read fifo and re-times its words into a
// valid/ready stream through a credit-managed skid buffer.
module fifo_pop_adapter
  import buff_pkg::*;
#(
  parameter int DATA_WIDTH = DATA_WIDTH_DEF,
  parameter int SKID_DEPTH = SKID_DEPTH_DEF
) (
  input  logic                          clk,
  input  logic                          reset_i,
  input  logic [DATA_WIDTH-1:0]         fifo_data_i,
  input  logic                          fifo_valid_i,
  output logic                          fifo_ready_o,
  output logic [DATA_WIDTH-1:0]         data_o,
  output logic                          data_o_valid,
  input  logic                          data_o_ready,
  output logic [$clog2(SKID_DEPTH):0]   occupancy_o,
  output logic                          err_o
);

  localparam int IDX_W = idx_w(SKID_DEPTH);
  localparam int CNT_W = $clog2(SKID_DEPTH) + 1;
  localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(SKID_DEPTH);

  logic [CNT_W-1:0] count;
  logic [CNT_W-1:0] count_nxt;
  logic [CNT_W-1:0] credit;
  logic [IDX_W-1:0] wr_ptr;
  logic [IDX_W-1:0] rd_ptr;
  logic             inflight_r;
  logic             post_rst_r;
  logic             err_r;
  logic             push;
  logic             pop;
  logic             perr;

  // a slot is reserved for every outstanding pop
  assign credit = count + CNT_W'(inflight_r);

  assign fifo_ready_o = ~reset_i & ~post_rst_r
                      & (credit < DEPTH_C);

  assign push = fifo_valid_i & inflight_r;
  assign pop  = data_o_valid & data_o_ready;
  assign perr = fifo_valid_i & ~inflight_r & ~post_rst_r;

  assign data_o_valid = (count != '0);
  assign occupancy_o  = count;
  assign err_o        = err_r;

  // occupancy follows accepted pushes and downstream pops
  always_comb begin
    count_nxt = count;
    case ({push, pop})
      2'b10:   count_nxt = count + CNT_W'(1);
      2'b01:   count_nxt = count - CNT_W'(1);
      default: count_nxt = count;
    endcase
  end

  // credit state, pointers and sticky protocol error
  always_ff @(posedge clk) begin
    if (reset_i) begin
      count      <= '0;
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      inflight_r <= 1'b0;
      post_rst_r <= 1'b1;
      err_r      <= 1'b0;
    end else begin
      count      <= count_nxt;
      inflight_r <= fifo_ready_o;
      post_rst_r <= 1'b0;
      if (push) begin
        wr_ptr <= wr_ptr + IDX_W'(1);
      end
      if (pop) begin
        rd_ptr <= rd_ptr + IDX_W'(1);
      end
      if (perr) begin
        err_r <= 1'b1;
      end
    end
  end

  skid_mem #(
    .DEPTH (SKID_DEPTH),
    .WIDTH (DATA_WIDTH),
    .IDX_W (IDX_W)
  ) u_mem (
    .clk   (clk),
    .we    (push),
    .waddr (wr_ptr),
    .wdata (fifo_data_i),
    .raddr (rd_ptr),
    .rdata (data_o)
  );

endmodule
